// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned) with valid/ready handshakes and flush.
// Optional macro DIV_EARLY_OUT_EN: skip iterations when |x| < |y| (y != 0).
module iter_divider #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero
);

  localparam int unsigned EXT_W = WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sign_q_q, sign_q_d;
  logic             sign_r_q, sign_r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
`ifdef DIV_EARLY_OUT_EN
  logic             early_q, early_d;
`endif

  logic [WIDTH-1:0] abs_x, abs_y;
  logic [EXT_W-1:0] shifted, trial;

  // Operand magnitudes; 0x80000000 maps to itself and is treated as unsigned.
  always_comb begin
    abs_x = (div_signed && x[WIDTH-1]) ? (WIDTH'(0) - x) : x;
    abs_y = (div_signed && y[WIDTH-1]) ? (WIDTH'(0) - y) : y;
  end

  // One restoring step on the {rem, quo} pair.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    sign_q_d    = sign_q_q;
    sign_r_d    = sign_r_q;
    q_d         = q_q;
    r_d         = r_q;
    dz_d        = dz_q;
    out_valid_d = out_valid_q;
`ifdef DIV_EARLY_OUT_EN
    early_d     = early_q;
`endif

    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      cnt_d       = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            rem_d    = '0;
            quo_d    = abs_x;
            dvs_d    = abs_y;
            sign_q_d = div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
            sign_r_d = div_signed & x[WIDTH-1];
            dz_d     = (y == '0);
            cnt_d    = '0;
            state_d  = CALC;
`ifdef DIV_EARLY_OUT_EN
            // Short-circuit: quotient is zero and the remainder is the dividend magnitude.
            early_d  = (y != '0) && (abs_x < abs_y);
            if ((y != '0) && (abs_x < abs_y)) begin
              rem_d = abs_x;
              quo_d = '0;
            end
`endif
          end
        end
        CALC: begin
          if (!trial[EXT_W-1]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = CNT_W'(cnt_q + 1'b1);
          if (cnt_q == LAST_ITER) begin
            state_d = FIX;
          end
`ifdef DIV_EARLY_OUT_EN
          if (early_q) begin
            rem_d   = rem_q;
            quo_d   = quo_q;
            cnt_d   = cnt_q;
            state_d = FIX;
          end
`endif
        end
        FIX: begin
          q_d         = sign_q_q ? (WIDTH'(0) - quo_q) : quo_q;
          r_d         = sign_r_q ? (WIDTH'(0) - rem_q) : rem_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          cnt_d       = '0;
        end
      endcase
    end

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      q_q         <= '0;
      r_q         <= '0;
      dz_q        <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
      early_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      sign_q_q    <= sign_q_d;
      sign_r_q    <= sign_r_d;
      q_q         <= q_d;
      r_q         <= r_d;
      dz_q        <= dz_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef DIV_EARLY_OUT_EN
      early_q     <= early_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign r         = r_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_iter_divider.sv
// Randomized and directed checks of iter_divider against an arithmetic reference model.
`timescale 1ns/1ps
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        div_signed;
  logic [31:0] x, y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] q, r;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  iter_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .div_signed(div_signed), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .r(r), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Reference: divide magnitudes with plain arithmetic, then apply result signs.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] eq, output logic [31:0] er,
                                  output logic edz, output int elat);
    logic [31:0] ma, mb, qm, rm;
    logic        neg_a, neg_b;
    neg_a = s && a[31];
    neg_b = s && b[31];
    ma = neg_a ? 32'(-a) : a;
    mb = neg_b ? 32'(-b) : b;
    if (b == 32'd0) begin
      qm = 32'hFFFF_FFFF;
      rm = ma;
    end else begin
      qm = ma / mb;
      rm = ma % mb;
    end
    eq  = (neg_a != neg_b) ? 32'(-qm) : qm;
    er  = neg_a ? 32'(-rm) : rm;
    edz = (b == 32'd0);
`ifdef DIV_EARLY_OUT_EN
    elat = (b != 32'd0 && ma < mb) ? 2 : 33;
`else
    elat = 33;
`endif
  endfunction

  // Issue one operation and wait (bounded) for out_valid; leaves the result pending.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] gq, output logic [31:0] gr,
                       output logic gdz, output int lat);
    in_valid   = 1'b1;
    x          = a;
    y          = b;
    div_signed = s;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    x          = $urandom;
    y          = $urandom;
    div_signed = 1'($urandom);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid === 1'b1) break;
    end
    gq  = q;
    gr  = r;
    gdz = div_zero;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({in_ready, out_valid, q, r, div_zero} !== {1'b1, 1'b0, 32'd0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b q=%h r=%h dz=%b", in_ready, out_valid, q, r, div_zero);
    end
    resetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [7];
    logic [31:0] tb [7];
    logic        ts [7];
    logic [31:0] gq, gr, eq, er;
    logic        gdz, edz;
    int          lat, elat;
    ta[0] = 32'd7;          tb[0] = 32'd2;          ts[0] = 1'b0;
    ta[1] = 32'hFFFF_FFF9;  tb[1] = 32'd2;          ts[1] = 1'b1;
    ta[2] = 32'd7;          tb[2] = 32'hFFFF_FFFE;  ts[2] = 1'b1;
    ta[3] = 32'h1234_5678;  tb[3] = 32'd0;          ts[3] = 1'b0;
    ta[4] = 32'h8000_0000;  tb[4] = 32'hFFFF_FFFF;  ts[4] = 1'b1;
    ta[5] = 32'd3;          tb[5] = 32'd10;         ts[5] = 1'b0;
    ta[6] = 32'hFFFF_FFF0;  tb[6] = 32'd0;          ts[6] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      do_op(ta[i], tb[i], ts[i], gq, gr, gdz, lat);
      ref_div(ta[i], tb[i], ts[i], eq, er, edz, elat);
      // Hand-derived values from the worked examples anchor the reference model.
      case (i)
        0: begin eq = 32'd3;          er = 32'd1;          end
        1: begin eq = 32'hFFFF_FFFD;  er = 32'hFFFF_FFFF;  end
        2: begin eq = 32'hFFFF_FFFD;  er = 32'd1;          end
        3: begin eq = 32'hFFFF_FFFF;  er = 32'h1234_5678;  end
        4: begin eq = 32'h8000_0000;  er = 32'd0;          end
        5: begin eq = 32'd0;          er = 32'd3;          end
        default: begin eq = 32'd1;    er = 32'hFFFF_FFF0;  end
      endcase
      checks++;
      if (gq !== eq || gr !== er || gdz !== edz) begin
        errors++;
        $display("FAIL directed_%0d got q=%h r=%h dz=%b exp q=%h r=%h dz=%b", i, gq, gr, gdz, eq, er, edz);
      end
      checks++;
      if (lat !== elat) begin
        errors++;
        $display("FAIL directed_lat_%0d got %0d exp %0d", i, lat, elat);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] gq, gr;
    logic        gdz;
    int          lat, bad;
    do_op(32'd1000, 32'd33, 1'b0, gq, gr, gdz, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (q !== 32'd30 || r !== 32'd10 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_hold got %0d bad cycles exp 0 (q=%h r=%h)", bad, q, r);
    end
    release_result();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_exit got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    logic [31:0] gq, gr;
    logic        gdz;
    int          lat;
    in_valid = 1'b1; x = 32'hDEAD_BEEF; y = 32'd3; div_signed = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; x = 32'd5; y = 32'd1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
    end
    do_op(32'd100, 32'd7, 1'b0, gq, gr, gdz, lat);
    checks++;
    if (gq !== 32'd14 || gr !== 32'd2 || gdz !== 1'b0 || lat !== 33) begin
      errors++;
      $display("FAIL flush_next got q=%h r=%h dz=%b lat=%0d exp q=e r=2 dz=0 lat=33", gq, gr, gdz, lat);
    end
    release_result();
  endtask

  task automatic test_async_reset();
    int seen;
    in_valid = 1'b1; x = 32'hFFFF_0000; y = 32'd9; div_signed = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, q, r, div_zero} !== {1'b1, 1'b0, 32'd0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got rdy=%b vld=%b q=%h r=%h dz=%b", in_ready, out_valid, q, r, div_zero);
    end
    @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL async_reset_no_result got %0d valid cycles exp 0", seen);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, gq, gr, eq, er;
    logic        s, gdz, edz;
    int          lat, elat;
    for (int n = 0; n < 1000; n++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom);
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 15);
        4: b = {$urandom_range(0, 1) == 0 ? 16'h0000 : 16'hFFFF, 16'($urandom)};
        default: ;
      endcase
      do_op(a, b, s, gq, gr, gdz, lat);
      ref_div(a, b, s, eq, er, edz, elat);
      checks++;
      if (gq !== eq || gr !== er || gdz !== edz) begin
        errors++;
        $display("FAIL random_%0d x=%h y=%h s=%b got q=%h r=%h dz=%b exp q=%h r=%h dz=%b",
                 n, a, b, s, gq, gr, gdz, eq, er, edz);
      end
      checks++;
      if (lat !== elat) begin
        errors++;
        $display("FAIL random_lat_%0d got %0d exp %0d", n, lat, elat);
      end
      release_result();
    end
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    div_signed = 1'b0; x = '0; y = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
